// File: rtl/sobel_window_feeder.sv
// rtl/sobel_window_feeder.sv - two-line buffer producing vertically aligned pixel columns for a Sobel consumer
module sobel_window_feeder #(
    parameter int Y_DEPTH = 8,
    parameter int H_RES   = 640
) (
    input  logic               i_pclk,
    input  logic               i_arst,
    input  logic               i_vsync,
    input  logic               i_valid,
    input  logic [Y_DEPTH-1:0] i_pixel,
    output logic               o_valid,
    output logic [Y_DEPTH-1:0] o_pixel_11_11,
    output logic [Y_DEPTH-1:0] o_pixel_00_11,
    output logic [Y_DEPTH-1:0] o_pixel_01_11,
    output logic               o_eol,
    output logic [1:0]         o_row
);
    localparam int ADDR_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(H_RES - 1);

    localparam logic [1:0] TAG_LINE0 = 2'd0;
    localparam logic [1:0] TAG_LINE1 = 2'd1;
    localparam logic [1:0] TAG_RUN   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_LINE0, S_LINE1, S_RUN} state_t;

    state_t              state;
    state_t              cur_state;
    logic [ADDR_W-1:0]   col;
    logic [ADDR_W-1:0]   cur_col;
    logic                accept;
    logic                at_last;
    logic [1:0]          cur_tag;

    logic                v_d1;
    logic [Y_DEPTH-1:0]  pixel_d1;
    logic [ADDR_W-1:0]   col_d1;
    logic                eol_d1;
    logic [1:0]          tag_d1;

    logic [Y_DEPTH-1:0]  ram_mid [H_RES];
    logic [Y_DEPTH-1:0]  ram_top [H_RES];
    logic [Y_DEPTH-1:0]  mid_q;
    logic [Y_DEPTH-1:0]  top_q;

    // vsync overrides the frame position in the same cycle, so a pixel arriving with it is column 0 of line 0
    always_comb begin
        cur_state = i_vsync ? S_LINE0 : state;
        cur_col   = i_vsync ? '0 : col;
        accept    = i_valid && (cur_state != S_IDLE);
        at_last   = (cur_col == LAST_COL);
        case (cur_state)
            S_LINE1: cur_tag = TAG_LINE1;
            S_RUN:   cur_tag = TAG_RUN;
            default: cur_tag = TAG_LINE0;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_arst) begin
            state <= S_IDLE;
            col   <= '0;
        end else if (accept && at_last) begin
            col <= '0;
            case (cur_state)
                S_LINE0: state <= S_LINE1;
                S_LINE1: state <= S_RUN;
                default: state <= cur_state;
            endcase
        end else if (accept) begin
            col   <= cur_col + 1'b1;
            state <= cur_state;
        end else begin
            col   <= cur_col;
            state <= cur_state;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_arst) begin
            v_d1     <= 1'b0;
            pixel_d1 <= '0;
            col_d1   <= '0;
            eol_d1   <= 1'b0;
            tag_d1   <= TAG_LINE0;
        end else begin
            v_d1 <= accept;
            if (accept) begin
                pixel_d1 <= i_pixel;
                col_d1   <= cur_col;
                eol_d1   <= at_last;
                tag_d1   <= cur_tag;
            end
        end
    end

    // Contents are never cleared; stale data is hidden by the LINE0/LINE1 padding
    always_ff @(posedge i_pclk) begin
        if (accept) begin
            mid_q <= ram_mid[cur_col];
            top_q <= ram_top[cur_col];
        end
        if (v_d1) begin
            ram_mid[col_d1] <= pixel_d1;
            ram_top[col_d1] <= mid_q;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_arst) begin
            o_valid       <= 1'b0;
            o_eol         <= 1'b0;
            o_row         <= 2'd0;
            o_pixel_11_11 <= '0;
            o_pixel_00_11 <= '0;
            o_pixel_01_11 <= '0;
        end else begin
            o_valid <= v_d1;
            o_eol   <= v_d1 && eol_d1;
            if (v_d1) begin
                o_row         <= tag_d1;
                o_pixel_01_11 <= pixel_d1;
                o_pixel_00_11 <= (tag_d1 != TAG_LINE0) ? mid_q : '0;
                o_pixel_11_11 <= (tag_d1 == TAG_RUN) ? top_q : '0;
            end
        end
    end
endmodule

// File: doc/sobel_window_feeder.md
Name: sobel_window_feeder

Overview:
- Producer side of the Sobel-Feldman column interface. Takes a raster luma stream, one pixel per valid cycle, and buffers two previous lines in on-chip RAM.
- Emits three vertically aligned pixels per column on o_pixel_11_11 (row y-2, top), o_pixel_00_11 (row y-1, middle) and o_pixel_01_11 (row y, bottom).
- Sits between the capture/scaler path and sobel_feldman. Rows above the frame top are zero-padded.

Parameters:
Y_DEPTH, 8, pixel bit width
H_RES, 640, active pixels per line; column counter wraps at H_RES-1
ADDR_W, $clog2(H_RES), line-RAM address width (derived, not overridden)

Ports:
i_pclk  in  1  pixel clock; all logic on rising edge
i_arst  in  1  reset, synchronous, active-high
i_vsync  in  1  one-cycle frame-start pulse; precedes first pixel of a frame
i_valid  in  1  i_pixel qualifier
i_pixel  in  Y_DEPTH  incoming luma, raster order
o_valid  out  1  output column qualifier
o_pixel_11_11  out  Y_DEPTH  top row (y-2) pixel
o_pixel_00_11  out  Y_DEPTH  middle row (y-1) pixel
o_pixel_01_11  out  Y_DEPTH  bottom row (y) pixel, the current input
o_eol  out  1  high with o_valid on last column (H_RES-1) of each line
o_row  out  2  fill state seen by consumer: 0=line0, 1=line1, 2=steady

Behaviour:
- Reset (i_arst=1 at edge): state S_IDLE; column/row counters 0; pipeline valids cleared. All outputs 0. Line-RAM contents are not cleared; zero padding masks them.
- FSM states: S_IDLE, S_LINE0, S_LINE1, S_RUN.
  - S_IDLE -> S_LINE0 on i_vsync.
  - S_LINE0 -> S_LINE1 and S_LINE1 -> S_RUN on accepted pixel at column H_RES-1.
  - S_RUN stays until i_vsync.
  - i_vsync in any state -> S_LINE0, column=0.
- i_valid in S_IDLE is ignored: no RAM write, no output.
- Line RAMs: two simple dual-port RAMs (RAM_MID holds y-1, RAM_TOP holds y-2), depth H_RES, synchronous read, addressed by column.
- Pipeline, fixed latency 2 cycles from accepted i_valid to o_valid:
  - Stage 1 (cycle t): read both RAMs at column; register pixel, column, eol flag, state tag.
  - Stage 2 (cycle t+1): write RAM_MID[col]=pixel_d1 and RAM_TOP[col]=RAM_MID read data (cascade); register outputs.
- Output mux by state tag captured at stage 1:
  - LINE0: top=0, mid=0, bottom=pixel.
  - LINE1: top=0, mid=RAM_MID q, bottom=pixel.
  - RUN: top=RAM_TOP q, mid=RAM_MID q, bottom=pixel.
- Read and write target the same column only one line apart, so there is no read/write collision within a line.
- Gaps: i_valid may drop on any cycle. Counters and RAM writes advance only on accepted pixels. o_valid is a pure 2-cycle delay of accepted i_valid, so no bubble is inserted or removed.
- o_eol asserts only together with o_valid. o_row reports the stage-2 tag (0/1/2).
- Column wrap: H_RES-1 -> 0 and row state advances in the same cycle. Back-to-back lines need no idle cycle.
- i_vsync together with i_valid in the same cycle: vsync wins. That pixel is accepted as column 0 of line 0 of the new frame.
- i_vsync mid-line:
  - Partial line is abandoned; in-flight stage-1/2 entries still complete and are output.
  - RAM contents are stale but are masked by LINE0/LINE1 padding.
- Reset mid-frame: next edge clears pipeline and outputs. No pixel is emitted until a new i_vsync.
- Pixel values pass through unmodified; no arithmetic or saturation. Full range 0..2^Y_DEPTH-1.

Test Plan:
- Reset: hold i_arst 3 cycles with i_valid=1, i_pixel=8'hFF -> o_valid=0, all o_pixel=0, o_eol=0, o_row=0. No output until i_vsync.
- Frame fill, H_RES=4, pixel=row*16+col, continuous valid:
  - line0 col2 -> (0,0,8'h02).
  - line1 col3 -> (0,8'h03,8'h13) with o_eol=1.
  - line3 col1 -> (8'h11,8'h21,8'h31), o_row=2.
  - each appears exactly 2 cycles after input.
- Valid gaps, H_RES=4: insert 1-3 idle cycles between every pixel of lines 2-3 -> identical column triples as the continuous run, and o_valid count equals input count (16).
- Mid-line vsync, H_RES=4: pulse i_vsync at line2 col2, then resend frame with pixel=8'h80+col -> col0/col1 in-flight outputs still appear; new line0 col0 -> (0,0,8'h80).
- Reset mid-frame: assert i_arst for 1 cycle at line3 col1 -> outputs 0 the next cycle, none until vsync. Post-vsync line0 has top=mid=0.
- Extremes, H_RES=4: lines of all 8'hFF then all 8'h00 -> line2 triples (8'hFF,8'hFF,8'h00) exactly. No wrap or corruption at the max value.
